ext_irq_ctrl: RTL and testbench

- External interrupt controller feeding the privilege unit's `eip`/`eip_reply` pair.
- Collects single-cycle irq pulses from up to NSRC peripherals (UART, SD, GPIO, ...) and latches them as pending.
- Holds `eip` high until the privilege unit replies, then claims the highest-priority enabled source.
- The trap handler reads the claim ID and writes it back to complete service, over a small CSR-style register port.

---
 rtl/ext_irq_ctrl_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/ext_irq_ctrl.sv | 118 +++++++++++
 tb/tb_ext_irq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register map,
// FSM state encoding and default sizing.
package ext_irq_ctrl_pkg;

  localparam int NSRC_DEF = 8;
  localparam int IDW_DEF  = 5;

  localparam logic [2:0] REG_PENDING  = 3'd0;
  localparam logic [2:0] REG_ENABLE   = 3'd1;
  localparam logic [2:0] REG_CLAIM    = 3'd2;
  localparam logic [2:0] REG_COMPLETE = 3'd3;
  localparam logic [2:0] REG_FORCE    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; source i reports ID i+1, ID 0 = none.
module irq_prio_enc #(
  parameter int NSRC = 8,
  parameter int IDW  = 5
) (
  input  logic [NSRC-1:0] mask_i,
  output logic            vld_o,
  output logic [IDW-1:0]  id_o
);

  // Walk downward so the lowest set index is the last to write id_o.
  always_comb begin
    id_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (mask_i[i]) id_o = IDW'(i + 1);
    end
    vld_o = |mask_i;
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: latches irq pulses as pending, raises eip,
// hands out a claim on reply and waits for software to complete it.
module ext_irq_ctrl
  import ext_irq_ctrl_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic [2:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  output logic [31:0]     spo,
  output logic            eip,
  input  logic            eip_reply
);

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [IDW-1:0]  claim_q, claim_d;
  logic            eip_q, eip_d;

  logic [NSRC-1:0] force_bits, clr_bits;
  logic            wr_cmp;
  logic            win_vld;
  logic [IDW-1:0]  win_id;

  // Upper data bits are don't-care for the narrower registers.
  logic unused_d;
  assign unused_d = ^d;

  irq_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio (
    .mask_i (pend_q & en_q),
    .vld_o  (win_vld),
    .id_o   (win_id)
  );

  always_comb begin
    force_bits = (we && a == REG_FORCE) ? d[NSRC-1:0] : '0;
    wr_cmp     = we && a == REG_COMPLETE;
    en_d       = (we && a == REG_ENABLE) ? d[NSRC-1:0] : en_q;
  end

  always_comb begin
    state_d  = state_q;
    eip_d    = eip_q;
    claim_d  = claim_q;
    clr_bits = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_ARMED;
          eip_d   = 1'b1;
        end
      end
      ST_ARMED: begin
        if (eip_reply) begin
          eip_d = 1'b0;
          if (win_vld) begin
            claim_d = win_id;
            state_d = ST_BUSY;
            for (int i = 0; i < NSRC; i++) begin
              if (win_id == IDW'(i + 1)) clr_bits[i] = 1'b1;
            end
          end else begin
            claim_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BUSY: begin
        if (wr_cmp && d[IDW-1:0] == claim_q) begin
          claim_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        eip_d   = 1'b0;
        claim_d = '0;
      end
    endcase
    // A fresh pulse on the bit being claimed survives the clear.
    pend_d = (pend_q & ~clr_bits) | irq | force_bits;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      en_q    <= '0;
      claim_q <= '0;
      eip_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      claim_q <= claim_d;
      eip_q   <= eip_d;
    end
  end

  assign eip = eip_q;

  always_comb begin
    spo = '0;
    case (a)
      REG_PENDING: spo[NSRC-1:0] = pend_q;
      REG_ENABLE:  spo[NSRC-1:0] = en_q;
      REG_CLAIM:   spo[IDW-1:0]  = claim_q;
      default:     spo = '0;
    endcase
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl with hand-computed expectations.
module tb_ext_irq_ctrl;
  import ext_irq_ctrl_pkg::*;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq;
  logic [2:0]      a;
  logic [31:0]     d;
  logic            we;
  logic [31:0]     spo;
  logic            eip;
  logic            eip_reply;

  int n_pass = 0;
  int n_chk  = 0;

  ext_irq_ctrl #(.NSRC(NSRC), .IDW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .a         (a),
    .d         (d),
    .we        (we),
    .spo       (spo),
    .eip       (eip),
    .eip_reply (eip_reply)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    a = addr; d = data; we = 1'b1;
    step();
    we = 1'b0; d = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(tag, spo, exp);
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    irq = m;
    step();
    irq = '0;
  endtask

  task automatic reply();
    eip_reply = 1'b1;
    step();
    eip_reply = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; irq = '0; a = '0; d = '0; we = 1'b0; eip_reply = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eip", {31'd0, eip}, 32'd0);
    rd("rst_pend", REG_PENDING, 32'd0);
    rd("rst_en", REG_ENABLE, 32'd0);
    rd("rst_claim", REG_CLAIM, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single source: pending one edge after the pulse, eip one edge later.
    wr(REG_ENABLE, 32'h1);
    rd("en_rd", REG_ENABLE, 32'h1);
    pulse(8'h01);
    chk("s1_eip_n1", {31'd0, eip}, 32'd0);
    step();
    chk("s1_eip_n2", {31'd0, eip}, 32'd1);
    reply();
    chk("s1_eip_drop", {31'd0, eip}, 32'd0);
    rd("s1_claim", REG_CLAIM, 32'd1);
    rd("s1_pend", REG_PENDING, 32'd0);
    wr(REG_COMPLETE, 32'd1);
    rd("s1_claim_clr", REG_CLAIM, 32'd0);
    step();
    chk("s1_idle_eip", {31'd0, eip}, 32'd0);

    // Priority: sources 2 and 5 together, lowest index first.
    wr(REG_ENABLE, 32'hFF);
    pulse(8'h24);
    step();
    chk("pr_eip", {31'd0, eip}, 32'd1);
    reply();
    rd("pr_claim3", REG_CLAIM, 32'd3);
    rd("pr_pend", REG_PENDING, 32'h20);
    wr(REG_COMPLETE, 32'd3);
    step();
    chk("pr_rearm", {31'd0, eip}, 32'd1);
    reply();
    rd("pr_claim6", REG_CLAIM, 32'd6);
    wr(REG_COMPLETE, 32'd6);
    step();
    step();
    chk("pr_quiet", {31'd0, eip}, 32'd0);
    rd("pr_claim0", REG_CLAIM, 32'd0);

    // Masking: pending visible but held off until enabled.
    wr(REG_ENABLE, 32'h0);
    pulse(8'h10);
    rd("mk_pend", REG_PENDING, 32'h10);
    step();
    chk("mk_eip0", {31'd0, eip}, 32'd0);
    wr(REG_ENABLE, 32'h110);
    rd("mk_en_trunc", REG_ENABLE, 32'h10);
    chk("mk_eip_e1", {31'd0, eip}, 32'd0);
    step();
    chk("mk_eip_e2", {31'd0, eip}, 32'd1);
    reply();
    rd("mk_claim", REG_CLAIM, 32'd5);
    wr(REG_COMPLETE, 32'd5);

    // Same-cycle set and clear on source 0.
    wr(REG_ENABLE, 32'h1);
    pulse(8'h01);
    step();
    chk("sc_eip", {31'd0, eip}, 32'd1);
    irq = 8'h01; eip_reply = 1'b1;
    step();
    irq = '0; eip_reply = 1'b0;
    rd("sc_claim", REG_CLAIM, 32'd1);
    rd("sc_pend", REG_PENDING, 32'h1);
    wr(REG_COMPLETE, 32'd1);
    step();
    chk("sc_rearm", {31'd0, eip}, 32'd1);
    reply();
    wr(REG_COMPLETE, 32'd1);

    // Spurious claim: enable withdrawn while armed.
    wr(REG_ENABLE, 32'h2);
    wr(REG_FORCE, 32'h2);
    rd("sp_pend", REG_PENDING, 32'h2);
    step();
    chk("sp_eip", {31'd0, eip}, 32'd1);
    wr(REG_ENABLE, 32'h0);
    chk("sp_eip_held", {31'd0, eip}, 32'd1);
    reply();
    chk("sp_eip_drop", {31'd0, eip}, 32'd0);
    rd("sp_claim", REG_CLAIM, 32'd0);
    step();
    chk("sp_idle", {31'd0, eip}, 32'd0);

    // Wrong complete ignored; stray reply in BUSY ignored.
    wr(REG_ENABLE, 32'h2);
    step();
    chk("wc_eip", {31'd0, eip}, 32'd1);
    reply();
    rd("wc_claim", REG_CLAIM, 32'd2);
    wr(REG_COMPLETE, 32'd5);
    chk("wc_eip0", {31'd0, eip}, 32'd0);
    rd("wc_claim_kept", REG_CLAIM, 32'd2);
    reply();
    rd("wc_reply_ign", REG_CLAIM, 32'd2);
    rd("wc_rd_cmp", REG_COMPLETE, 32'd0);
    rd("wc_rd_force", REG_FORCE, 32'd0);
    rd("wc_rd_5", 3'd5, 32'd0);
    wr(REG_COMPLETE, 32'd2);
    rd("wc_done", REG_CLAIM, 32'd0);
    step();
    chk("wc_idle", {31'd0, eip}, 32'd0);

    // Asynchronous reset while eip is high.
    wr(REG_ENABLE, 32'h1);
    pulse(8'h01);
    step();
    chk("ar_eip", {31'd0, eip}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_eip0", {31'd0, eip}, 32'd0);
    rd("ar_en", REG_ENABLE, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    wr(REG_ENABLE, 32'h4);
    pulse(8'h04);
    step();
    chk("ar_post_eip", {31'd0, eip}, 32'd1);
    reply();
    rd("ar_post_claim", REG_CLAIM, 32'd3);
    wr(REG_COMPLETE, 32'd3);
    rd("ar_post_done", REG_CLAIM, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
